// File: rtl/arbitro_divisor_pkg.sv
// Shared types and defaults for the round-robin divider arbiter.
// Holds the FSM state encoding and the round-robin pointer wrap helper.
package arbitro_divisor_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DD_W_DEF  = 32;
  localparam int DV_W_DEF  = 16;
  localparam int Q_W_DEF   = 16;
  localparam int TMO_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Explicit wrap so that non-power-of-two requester counts cycle correctly.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
    return (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/arbitro_divisor_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping modulo N_REQ. Returns a one-hot grant and its index.
module arbitro_divisor_rr_picker
  import arbitro_divisor_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [2:0]       rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [2:0]       idx_o
);

  logic [2:0] cand [N_REQ];
  logic [7:0] req_pad;
  logic       hit;

  // cand[k] is the requester examined k-th, starting from the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum      = {1'b0, rr_ptr_i} + 4'(gi);
      assign cand[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
    end
  endgenerate

  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req_i;
    hit                  = 1'b0;
    idx_o                = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hit && req_pad[cand[k]]) begin
        hit   = 1'b1;
        idx_o = cand[k];
      end
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_o[gi] = hit && (idx_o == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/arbitro_divisor.sv
// Round-robin arbiter sharing one signed divide unit among N_REQ requesters.
// Sequences the go/done handshake, returns the quotient with a one-cycle ack.
module arbitro_divisor
  import arbitro_divisor_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DD_W  = DD_W_DEF,
  parameter int DV_W  = DV_W_DEF,
  parameter int Q_W   = Q_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic                  reloj,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DD_W-1:0] dd_in,
  input  logic [N_REQ*DV_W-1:0] dv_in,
  output logic [N_REQ-1:0]      ack,
  output logic [Q_W-1:0]        q_out,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  div_go,
  output logic [DD_W-1:0]       div_dd,
  output logic [DV_W-1:0]       div_dv,
  input  logic [Q_W-1:0]        div_quotient,
  input  logic                  div_done
);

  state_e             state_q;
  logic [N_REQ-1:0]   ack_q;
  logic [N_REQ-1:0]   ack_d;
  logic [Q_W-1:0]     q_out_q;
  logic               err_q;
  logic               div_go_q;
  logic [DD_W-1:0]    div_dd_q;
  logic [DV_W-1:0]    div_dv_q;
  logic [2:0]         grant_id_q;
  logic [2:0]         rr_ptr_q;
  logic [2:0]         rr_ptr_d;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_d;
  logic               tmo_expired;

  logic [N_REQ-1:0]   pick_grant;
  logic [2:0]         pick_idx;
  logic [DD_W-1:0]    dd_arr [8];
  logic [DV_W-1:0]    dv_arr [8];

  arbitro_divisor_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx)
  );

  // Operand lanes padded to 8 so the 3-bit grant index always selects cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < N_REQ) begin : g_used
        assign dd_arr[gi] = dd_in[gi*DD_W +: DD_W];
        assign dv_arr[gi] = dv_in[gi*DV_W +: DV_W];
      end else begin : g_pad
        assign dd_arr[gi] = '0;
        assign dv_arr[gi] = '0;
      end
    end
    for (gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign ack_d[gi] = (grant_id_q == 3'(gi));
    end
  endgenerate

  assign rr_ptr_d    = wrap_inc(grant_id_q, N_REQ);
  assign tmo_d       = tmo_q + TMO_W'(1);
  assign tmo_expired = (tmo_q == '1);

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      err_q      <= 1'b0;
      div_go_q   <= 1'b0;
      q_out_q    <= '0;
      div_dd_q   <= '0;
      div_dv_q   <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A divider still busy (done low) blocks new grants.
          if ((|pick_grant) && div_done) begin
            div_dd_q   <= dd_arr[pick_idx];
            div_dv_q   <= dv_arr[pick_idx];
            grant_id_q <= pick_idx;
            div_go_q   <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tmo_q   <= '0;
          state_q <= ST_START;
        end
        ST_START: begin
          if (!div_done) begin
            div_go_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= ST_RUN;
          end else if (tmo_expired) begin
            div_go_q <= 1'b0;
            q_out_q  <= '0;
            err_q    <= 1'b1;
            ack_q    <= ack_d;
            state_q  <= ST_RESP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_RUN: begin
          if (div_done) begin
            q_out_q <= div_quotient;
            ack_q   <= ack_d;
            state_q <= ST_RESP;
          end else if (tmo_expired) begin
            q_out_q <= '0;
            err_q   <= 1'b1;
            ack_q   <= ack_d;
            state_q <= ST_RESP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_RESP: begin
          ack_q    <= '0;
          err_q    <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign q_out    = q_out_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;
  assign div_go   = div_go_q;
  assign div_dd   = div_dd_q;
  assign div_dv   = div_dv_q;

endmodule

// File: tb/tb_arbitro_divisor.sv
// Bench for arbitro_divisor: behavioural divider with configurable delay/hang,
// expected acks queued at stimulus time and checked as each ack appears.
module tb_arbitro_divisor;

  localparam int N   = 4;
  localparam int DDW = 32;
  localparam int DVW = 16;
  localparam int QW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*DDW-1:0] dd_in = '0;
  logic [N*DVW-1:0] dv_in = '0;
  logic [N-1:0]     ack;
  logic [QW-1:0]    q_out;
  logic             err;
  logic             busy;
  logic [2:0]       grant_id;
  logic             div_go;
  logic [DDW-1:0]   div_dd;
  logic [DVW-1:0]   div_dv;
  logic [QW-1:0]    div_quotient = '0;
  logic             div_done = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            idx;
    logic [QW-1:0] q;
    logic          e;
    bit            use_q;
  } exp_t;
  exp_t sb[$];

  arbitro_divisor dut (
    .reloj        (clk),
    .reset        (rst_n),
    .req          (req),
    .dd_in        (dd_in),
    .dv_in        (dv_in),
    .ack          (ack),
    .q_out        (q_out),
    .err          (err),
    .busy         (busy),
    .grant_id     (grant_id),
    .div_go       (div_go),
    .div_dd       (div_dd),
    .div_dv       (div_dv),
    .div_quotient (div_quotient),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  // Behavioural divide unit, negedge-updated, with delay and hang controls.
  int            m_dly = 6;
  bit            m_hang = 1'b0;
  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  logic [QW-1:0] m_res = '0;

  function automatic logic [QW-1:0] ref_div(input int a, input int b);
    if (b == 0) return '1;
    return QW'(a / b);
  endfunction

  always @(negedge clk) begin
    if (m_busy) begin
      if (!m_hang) begin
        if (m_cnt <= 1) begin
          div_done     <= 1'b1;
          div_quotient <= m_res;
          m_busy       <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (div_go && div_done) begin
      div_done <= 1'b0;
      m_busy   <= 1'b1;
      m_cnt    <= m_dly;
      m_res    <= ref_div(int'($signed(div_dd)), int'($signed(div_dv)));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int dd, input int dv);
    dd_in[i*DDW +: DDW] = DDW'(dd);
    dv_in[i*DVW +: DVW] = DVW'(dv);
  endtask

  task automatic push(input int idx, input logic [QW-1:0] q, input logic e, input bit use_q);
    exp_t x;
    x.idx = idx; x.q = q; x.e = e; x.use_q = use_q;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input int budget);
    int   n;
    exp_t x;
    n = 0;
    while (ack == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", 64'(ack != '0), 64'd1);
    if (ack != '0) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        x = sb.pop_front();
        check("ack_vec", 64'(ack), 64'd1 << x.idx);
        if (x.use_q) check("q_out", 64'(q_out), 64'(x.q));
        check("err", 64'(err), 64'(x.e));
        check("busy_resp", 64'(busy), 64'd1);
        check("grant_id", 64'(grant_id), 64'(x.idx));
        $display("txn req=%0d ack=%b q_out=%h err=%b waited=%0d", x.idx, ack, q_out, err, n);
        req[x.idx] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_q", 64'(q_out), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_go", 64'(div_go), 64'd0);
    check("rst_dd", 64'(div_dd), 64'd0);
    check("rst_dv", 64'(div_dv), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    set_op(0, 100, 7);
    push(0, 16'd14, 1'b0, 1'b1);
    req = 4'b0001;
    @(negedge clk);
    check("go_load", 64'(div_go), 64'd1);
    check("dd_load", 64'(div_dd), 64'd100);
    check("dv_load", 64'(div_dv), 64'd7);
    check("busy_grant", 64'(busy), 64'd1);
    wait_ack(100);
    check("busy_idle", 64'(busy), 64'd0);
    check("go_idle", 64'(div_go), 64'd0);

    // Divisor zero from requester 3: acks without error, pointer wraps to 0
    set_op(3, 5, 0);
    push(3, '0, 1'b0, 1'b0);
    req = 4'b1000;
    wait_ack(100);
    check("busy_dz", 64'(busy), 64'd0);

    // All requests; requester 0 re-asserts right after its ack
    for (int i = 0; i < N; i++) set_op(i, 1000 * (i + 1), i + 3);
    for (int i = 0; i < N; i++) push(i, ref_div(1000 * (i + 1), i + 3), 1'b0, 1'b1);
    push(0, ref_div(1000, 3), 1'b0, 1'b1);
    req = 4'b1111;
    wait_ack(100);
    req[0] = 1'b1;
    repeat (4) wait_ack(100);

    // Signed operands
    set_op(1, -100, 7);
    push(1, 16'hFFF2, 1'b0, 1'b1);
    req = 4'b0010;
    wait_ack(100);
    set_op(1, 100, -7);
    push(1, 16'hFFF2, 1'b0, 1'b1);
    req = 4'b0010;
    wait_ack(100);

    // Divider hangs: watchdog acks with err and zero quotient
    m_hang = 1'b1;
    set_op(2, 50, 5);
    push(2, 16'h0000, 1'b1, 1'b1);
    req = 4'b0100;
    wait_ack(400);
    m_hang = 1'b0;
    check("busy_tmo", 64'(busy), 64'd0);
    set_op(3, -7000, 3);
    push(3, 16'hF6E3, 1'b0, 1'b1);
    req = 4'b1000;
    wait_ack(100);
    set_op(1, -100, -7);
    push(1, 16'd14, 1'b0, 1'b1);
    req = 4'b0010;
    wait_ack(100);

    // Reset in the middle of RUN, then re-grant from requester 0
    m_dly = 20;
    set_op(0, 700, 7);
    set_op(2, -900, 9);
    set_op(3, 12345, -5);
    req = 4'b1101;
    repeat (6) @(negedge clk);
    check("busy_run", 64'(busy), 64'd1);
    check("gid_run", 64'(grant_id), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ack", 64'(ack), 64'd0);
    check("mid_q", 64'(q_out), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_go", 64'(div_go), 64'd0);
    check("mid_dd", 64'(div_dd), 64'd0);
    check("mid_dv", 64'(div_dv), 64'd0);
    check("mid_gid", 64'(grant_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    push(0, ref_div(700, 7), 1'b0, 1'b1);
    push(2, ref_div(-900, 9), 1'b0, 1'b1);
    push(3, ref_div(12345, -5), 1'b0, 1'b1);
    repeat (3) wait_ack(200);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
